ahb_gpio_port: RTL and testbench
================================

AHB_GPIO_PORT -- requirements
Module: ahb_gpio_port

Interface
REQ-001 SHALL have parameter OUT_RESET, default 32'h0000_0000, the reset value of DATA_OUT.
REQ-002 SHALL have parameter OE_RESET, default 32'h0000_0000, the reset value of OE.
REQ-003 SHALL have port HCLK, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port HRESET, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port HSEL, input, 1 bit, AHB-Lite slave select.
REQ-006 SHALL have port HADDR, input, 32 bits; only HADDR[4:2] is decoded.
REQ-007 SHALL have port HTRANS, input, 2 bits; NONSEQ or SEQ marks a valid transfer.
REQ-008 SHALL have port HWRITE, input, 1 bit, 1 = write.
REQ-009 SHALL have port HSIZE, input, 3 bits, transfer size.
REQ-010 SHALL have port HREADY, input, 1 bit, bus-level ready.
REQ-011 SHALL have port HWDATA, input, 32 bits, write data (data phase).
REQ-012 SHALL have port HRDATA, output, 32 bits, read data (data phase).
REQ-013 SHALL have port HREADYOUT, output, 1 bit, slave ready.
REQ-014 SHALL have port HRESP, output, 1 bit, slave response.
REQ-015 SHALL have port GPIO_OUT, output, 32 bits, pin output values.
REQ-016 SHALL have port GPIO_OE, output, 32 bits, per-pin output enable.
REQ-017 SHALL have port GPIO_IN, input, 32 bits, asynchronous pin input values.
REQ-018 SHALL have port IRQ, output, 1 bit, level interrupt.

Function
REQ-019 SHALL capture HADDR[4:2], HWRITE and a valid flag at each rising edge with HSEL & HREADY & HTRANS[1]; with HREADY=1 and no qualifying transfer, the valid flag SHALL clear.
REQ-020 SHALL drive HREADYOUT=1 and HRESP=0 at all times (zero wait states, no errors).
REQ-021 SHALL use this register map (offset: name, access): 0x00 DATA_OUT RW; 0x04 OE RW; 0x08 DATA_IN RO; 0x0C IRQ_EN RW; 0x10 IRQ_STATUS R/W1C; 0x14 OUT_SET WO; 0x18 OUT_CLR WO; 0x1C reserved.
REQ-022 SHALL commit a write at the rising edge that ends its data phase, using HWDATA; GPIO_OUT and GPIO_OE SHALL reflect the new value from that edge onward.
REQ-023 SHALL ignore writes whose HSIZE is not 3'b010; reads SHALL always return the full word.
REQ-024 SHALL update DATA_OUT on an OUT_SET write to DATA_OUT | HWDATA, and on an OUT_CLR write to DATA_OUT & ~HWDATA.
REQ-025 SHALL ignore writes to DATA_IN, to 0x1C, and to addresses outside the decoded range.
REQ-026 SHALL drive HRDATA combinationally during a valid read data phase from the latched address; DATA_IN, OUT_SET, OUT_CLR and 0x1C SHALL read as DATA_IN, 0, 0 and 0 respectively; outside a valid read data phase HRDATA SHALL be 0.
REQ-027 SHALL return the newly written value when a read to an address directly follows a write to the same address.
REQ-028 SHALL pass GPIO_IN through a two-flop synchronizer; DATA_IN SHALL be the second stage, and a third register PREV SHALL hold DATA_IN delayed by one cycle.
REQ-029 SHALL set IRQ_STATUS bit i on the edge where DATA_IN[i]=1 and PREV[i]=0 (rising edge detect), independent of IRQ_EN.
REQ-030 SHALL clear IRQ_STATUS bits written with 1; when a set and a clear hit the same bit in the same cycle, the set SHALL win.
REQ-031 SHALL drive IRQ = |(IRQ_STATUS & IRQ_EN) combinationally from registers.
REQ-032 SHALL show a GPIO_IN rising edge that is stable before edge K as follows: in DATA_IN after K+1, in IRQ_STATUS after K+2.

Reset
REQ-033 SHALL, while HRESET=1 at a rising edge, set DATA_OUT=OUT_RESET, OE=OE_RESET, IRQ_EN=0, IRQ_STATUS=0, all synchronizer stages and PREV=0, and clear the valid flag.
REQ-034 SHALL discard any write whose data phase coincides with reset.
REQ-035 SHALL hold IRQ=0 and HRDATA=0 during reset.

Verification
REQ-036 SHALL cover: write 0xF00FE00E to 0x00 and 0xFFFFFFFF to 0x04 -> GPIO_OUT=0xF00FE00E and GPIO_OE=0xFFFFFFFF the cycle after each data phase; read-back of 0x00 returns 0xF00FE00E.
REQ-037 SHALL cover: DATA_OUT=0x0000FF00, write 0x0000000F to 0x14, then 0x00000F00 to 0x18 -> GPIO_OUT goes 0x0000FF0F, then 0x0000F00F.
REQ-038 SHALL cover: drive GPIO_IN 0 to 0x00000005 -> read of 0x08 returns 5 two cycles later; IRQ_STATUS=0x5; with IRQ_EN=0x4, IRQ=1; write 0x4 to 0x10 -> IRQ=0 and IRQ_STATUS=0x1.
REQ-039 SHALL cover: W1C of bit 0 on the same edge a new rising edge sets bit 0 -> bit 0 remains 1.
REQ-040 SHALL cover: a byte-size write (HSIZE=0) to 0x00, an IDLE transfer, and HSEL=0 transfers -> no register changes.
REQ-041 SHALL cover: assert HRESET during a write data phase -> the write is lost and all registers hold reset values; HREADYOUT stays 1 throughout.

Source files
------------

// File: rtl/ahb_gpio_port.sv
// AHB-Lite GPIO port: output/enable registers, synchronized inputs with
// rising-edge interrupt status, zero-wait-state slave interface.
module ahb_gpio_port #(
  parameter logic [31:0] OUT_RESET = 32'h0000_0000,
  parameter logic [31:0] OE_RESET  = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] GPIO_OUT,
  output logic [31:0] GPIO_OE,
  input  logic [31:0] GPIO_IN,
  output logic        IRQ
);

  typedef enum logic [2:0] {
    AddrOut   = 3'd0,
    AddrOe    = 3'd1,
    AddrIn    = 3'd2,
    AddrIrqEn = 3'd3,
    AddrIrqSt = 3'd4,
    AddrSet   = 3'd5,
    AddrClr   = 3'd6,
    AddrRsvd  = 3'd7
  } reg_addr_e;

  logic        valid_q, write_q, size_ok_q;
  reg_addr_e   addr_q;
  logic [31:0] out_q, out_d;
  logic [31:0] oe_q, oe_d;
  logic [31:0] irq_en_q, irq_en_d;
  logic [31:0] status_q, status_d;
  logic [31:0] sync_q, data_in_q, prev_q;
  logic [31:0] w1c;
  logic        xfer_req, wr_en;

  logic unused_bits;
  assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0]};

  assign xfer_req  = HSEL & HREADY & HTRANS[1];
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  // Address phase capture; held while another slave stretches the bus.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      valid_q   <= 1'b0;
      write_q   <= 1'b0;
      size_ok_q <= 1'b0;
      addr_q    <= AddrOut;
    end else if (HREADY) begin
      valid_q <= xfer_req;
      if (xfer_req) begin
        addr_q    <= reg_addr_e'(HADDR[4:2]);
        write_q   <= HWRITE;
        size_ok_q <= (HSIZE == 3'b010);
      end
    end
  end

  assign wr_en = valid_q & write_q & size_ok_q & HREADY;

  always_comb begin
    out_d    = out_q;
    oe_d     = oe_q;
    irq_en_d = irq_en_q;
    w1c      = '0;
    if (wr_en) begin
      case (addr_q)
        AddrOut:   out_d    = HWDATA;
        AddrOe:    oe_d     = HWDATA;
        AddrIrqEn: irq_en_d = HWDATA;
        AddrIrqSt: w1c      = HWDATA;
        AddrSet:   out_d    = out_q | HWDATA;
        AddrClr:   out_d    = out_q & ~HWDATA;
        default:   ;
      endcase
    end
    // A new rising edge overrides a same-cycle clear.
    status_d = (status_q & ~w1c) | (data_in_q & ~prev_q);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      out_q     <= OUT_RESET;
      oe_q      <= OE_RESET;
      irq_en_q  <= '0;
      status_q  <= '0;
      sync_q    <= '0;
      data_in_q <= '0;
      prev_q    <= '0;
    end else begin
      out_q     <= out_d;
      oe_q      <= oe_d;
      irq_en_q  <= irq_en_d;
      status_q  <= status_d;
      sync_q    <= GPIO_IN;
      data_in_q <= sync_q;
      prev_q    <= data_in_q;
    end
  end

  always_comb begin
    HRDATA = '0;
    if (valid_q && !write_q && !HRESET) begin
      case (addr_q)
        AddrOut:   HRDATA = out_q;
        AddrOe:    HRDATA = oe_q;
        AddrIn:    HRDATA = data_in_q;
        AddrIrqEn: HRDATA = irq_en_q;
        AddrIrqSt: HRDATA = status_q;
        default:   HRDATA = '0;
      endcase
    end
  end

  assign GPIO_OUT = out_q;
  assign GPIO_OE  = oe_q;
  assign IRQ      = ~HRESET & (|(status_q & irq_en_q));

endmodule

// File: tb/tb_ahb_gpio_port.sv
// Directed bench for ahb_gpio_port: bus writes/reads, set/clear, input
// synchronizer timing, interrupt status, ignored transfers and reset.
module tb_ahb_gpio_port;

  localparam logic [31:0] OutRst = 32'h0000_00A5;
  localparam logic [31:0] OeRst  = 32'h0000_00FF;

  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HWRITE, HREADY;
  logic [31:0] HADDR, HWDATA, GPIO_IN;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HRDATA, GPIO_OUT, GPIO_OE;
  logic        HREADYOUT, HRESP, IRQ;
  logic [31:0] rdata;

  int total  = 0;
  int passed = 0;

  ahb_gpio_port #(
    .OUT_RESET(OutRst),
    .OE_RESET (OeRst)
  ) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HREADY   (HREADY),
    .HWDATA   (HWDATA),
    .HRDATA   (HRDATA),
    .HREADYOUT(HREADYOUT),
    .HRESP    (HRESP),
    .GPIO_OUT (GPIO_OUT),
    .GPIO_OE  (GPIO_OE),
    .GPIO_IN  (GPIO_IN),
    .IRQ      (IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr_ph(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [31:0] addr, input logic [2:0] size);
    HSEL   = sel;
    HTRANS = trans;
    HWRITE = wr;
    HADDR  = addr;
    HSIZE  = size;
  endtask

  task automatic idle();
    addr_ph(1'b0, 2'b00, 1'b0, 32'h0, 3'd2);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] size);
    addr_ph(1'b1, 2'b10, 1'b1, addr, size);
    tick();
    idle();
    HWDATA = data;
    tick();
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    addr_ph(1'b1, 2'b10, 1'b0, addr, 3'd2);
    tick();
    idle();
    data = HRDATA;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET  = 1'b1;
    HREADY  = 1'b1;
    HWDATA  = '0;
    GPIO_IN = '0;
    idle();
    repeat (2) tick();
    addr_ph(1'b1, 2'b10, 1'b0, 32'h4, 3'd2);
    tick();
    idle();
    check("rst_out", GPIO_OUT, OutRst);
    check("rst_oe", GPIO_OE, OeRst);
    check("rst_hreadyout", HREADYOUT, 1'b1);
    check("rst_hresp", HRESP, 1'b0);
    check("rst_irq", IRQ, 1'b0);
    check("rst_hrdata", HRDATA, 32'h0);
    HRESET = 1'b0;
    tick();

    rd(32'h00, rdata);
    check("rd_out_rst", rdata, OutRst);

    // Basic output/enable writes and read-back.
    wr(32'h00, 32'hF00F_E00E, 3'd2);
    check("out_wr", GPIO_OUT, 32'hF00F_E00E);
    wr(32'h04, 32'hFFFF_FFFF, 3'd2);
    check("oe_wr", GPIO_OE, 32'hFFFF_FFFF);
    rd(32'h00, rdata);
    check("rd_out", rdata, 32'hF00F_E00E);
    rd(32'h04, rdata);
    check("rd_oe", rdata, 32'hFFFF_FFFF);

    // Read immediately following a write to the same address.
    addr_ph(1'b1, 2'b10, 1'b1, 32'h00, 3'd2);
    tick();
    HWDATA = 32'h0000_FF00;
    addr_ph(1'b1, 2'b10, 1'b0, 32'h00, 3'd2);
    tick();
    idle();
    check("b2b_rd", HRDATA, 32'h0000_FF00);
    check("b2b_out", GPIO_OUT, 32'h0000_FF00);
    tick();

    wr(32'h14, 32'h0000_000F, 3'd2);
    check("out_set", GPIO_OUT, 32'h0000_FF0F);
    wr(32'h18, 32'h0000_0F00, 3'd2);
    check("out_clr", GPIO_OUT, 32'h0000_F00F);
    rd(32'h14, rdata);
    check("rd_set_zero", rdata, 32'h0);
    rd(32'h18, rdata);
    check("rd_clr_zero", rdata, 32'h0);

    // Input edge stable before edge K: DATA_IN after K+1, status after K+2.
    GPIO_IN = 32'h0000_0005;
    addr_ph(1'b1, 2'b10, 1'b0, 32'h08, 3'd2);
    tick();
    check("din_after_k", HRDATA, 32'h0);
    tick();
    check("din_after_k1", HRDATA, 32'h5);
    addr_ph(1'b1, 2'b10, 1'b0, 32'h10, 3'd2);
    tick();
    check("sts_after_k2", HRDATA, 32'h5);
    idle();
    tick();
    check("irq_en_zero", IRQ, 1'b0);
    wr(32'h0C, 32'h4, 3'd2);
    check("irq_on", IRQ, 1'b1);
    wr(32'h10, 32'h4, 3'd2);
    check("irq_off_w1c", IRQ, 1'b0);
    rd(32'h10, rdata);
    check("sts_after_w1c", rdata, 32'h1);

    // Clear of bit 0 on the same edge a new rising edge sets it.
    GPIO_IN = 32'h0000_0004;
    repeat (4) tick();
    GPIO_IN = 32'h0000_0005;
    tick();
    addr_ph(1'b1, 2'b10, 1'b1, 32'h10, 3'd2);
    tick();
    idle();
    HWDATA = 32'h1;
    tick();
    rd(32'h10, rdata);
    check("set_wins", rdata, 32'h1);
    wr(32'h10, 32'h1, 3'd2);
    rd(32'h10, rdata);
    check("w1c_bit0", rdata, 32'h0);

    // Ignored transfers.
    wr(32'h00, 32'h1234_5678, 3'd0);
    check("byte_wr_ignored", GPIO_OUT, 32'h0000_F00F);
    wr(32'h04, 32'h0000_0000, 3'd1);
    check("half_wr_ignored", GPIO_OE, 32'hFFFF_FFFF);
    addr_ph(1'b1, 2'b00, 1'b1, 32'h00, 3'd2);
    tick();
    idle();
    HWDATA = 32'hFFFF_FFFF;
    check("hrdata_idle", HRDATA, 32'h0);
    tick();
    check("idle_ignored", GPIO_OUT, 32'h0000_F00F);
    addr_ph(1'b0, 2'b10, 1'b1, 32'h00, 3'd2);
    tick();
    idle();
    HWDATA = 32'hFFFF_FFFF;
    tick();
    check("hsel0_ignored", GPIO_OUT, 32'h0000_F00F);
    addr_ph(1'b1, 2'b10, 1'b1, 32'h00, 3'd2);
    HREADY = 1'b0;
    tick();
    HREADY = 1'b1;
    idle();
    HWDATA = 32'hFFFF_FFFF;
    tick();
    check("hready0_ignored", GPIO_OUT, 32'h0000_F00F);
    wr(32'h1C, 32'hFFFF_FFFF, 3'd2);
    rd(32'h1C, rdata);
    check("rd_rsvd", rdata, 32'h0);
    wr(32'h08, 32'h0000_0000, 3'd2);
    rd(32'h08, rdata);
    check("din_ro", rdata, 32'h5);

    // Raise IRQ, then reset during a write data phase.
    GPIO_IN = 32'h0;
    repeat (4) tick();
    GPIO_IN = 32'h0000_0004;
    repeat (4) tick();
    check("irq_pre_rst", IRQ, 1'b1);
    addr_ph(1'b1, 2'b10, 1'b1, 32'h00, 3'd2);
    tick();
    idle();
    HWDATA  = 32'hAAAA_AAAA;
    GPIO_IN = 32'h0;
    HRESET  = 1'b1;
    #1;
    check("irq_in_rst", IRQ, 1'b0);
    check("hready_in_rst", HREADYOUT, 1'b1);
    tick();
    check("rst_wr_lost", GPIO_OUT, OutRst);
    check("rst_oe2", GPIO_OE, OeRst);
    check("rst_hrdata2", HRDATA, 32'h0);
    tick();
    HRESET = 1'b0;
    rd(32'h0C, rdata);
    check("rst_irq_en", rdata, 32'h0);
    rd(32'h10, rdata);
    check("rst_sts", rdata, 32'h0);
    rd(32'h00, rdata);
    check("rst_rd_out", rdata, OutRst);
    check("hreadyout_end", HREADYOUT, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
